// File: rtl/fft_frame_feeder_if.sv
// Stream bundle between the recorder playback, the frame feeder and the xfft_1 input.
// The master side is the feeder: it consumes samples and drives the AXI-Stream words.
interface fft_frame_feeder_if #(
  parameter int SAMPLE_W = 8
);
  logic signed [SAMPLE_W-1:0] sample_in;
  logic                       sample_valid_in;
  logic                       sample_ready_out;
  logic [31:0]                m_axis_tdata;
  logic                       m_axis_tvalid;
  logic                       m_axis_tready;
  logic                       m_axis_tlast;

  modport master (
    input  sample_in, sample_valid_in, m_axis_tready,
    output sample_ready_out, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output sample_in, sample_valid_in, m_axis_tready,
    input  sample_ready_out, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/fft_frame_feeder.sv
// Slices a recording of known length into FFT frames of FRAME_LEN complex words,
// zero-padding the final partial frame, and reports frame progress.
//
// state  | meaning
// IDLE   | waiting for start_in; samples are dropped
// STREAM | moving samples through the elastic FIFO into the FFT
// PAD    | emitting zero words until the partial frame's tlast
// DONE   | one cycle with busy_out low, then back to IDLE
module fft_frame_feeder #(
  parameter int FRAME_LEN  = 1024,
  parameter int SAMPLE_W   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [31:0] total_samples_in,
  fft_frame_feeder_if.master bus,
  output logic        frame_done_out,
  output logic [15:0] frame_count_out,
  output logic        busy_out
);
  localparam int PW = $clog2(FRAME_LEN);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, PAD, DONE} state_t;

  state_t state, state_nxt;

  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr, fill;
  logic                fifo_empty, fifo_full;
  logic [31:0]         len, in_cnt;
  logic [PW-1:0]       pos;
  logic                last_pos, push, pop, out_hs, last_hs, start_ok;
  logic [15:0]         re_part;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign fill       = wr_ptr - rd_ptr;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == (AW+1)'(FIFO_DEPTH));
  assign last_pos   = (pos == PW'(FRAME_LEN - 1));
  assign start_ok   = (state == IDLE) && start_in;

  // Sample goes in the top bits of the real part; no sign extension upward.
  assign re_part = 16'(bus.sample_in) & 16'h0000 | {mem[rd_ptr[AW-1:0]], {(16-SAMPLE_W){1'b0}}};

  assign push    = bus.sample_valid_in && bus.sample_ready_out;
  assign out_hs  = bus.m_axis_tvalid && bus.m_axis_tready;
  assign last_hs = out_hs && bus.m_axis_tlast;
  assign pop     = out_hs && (state == STREAM);

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/output decode.
  always_comb begin
    state_nxt            = state;
    bus.sample_ready_out = 1'b0;
    bus.m_axis_tvalid    = 1'b0;
    bus.m_axis_tdata     = 32'h0;
    bus.m_axis_tlast     = 1'b0;
    busy_out             = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) state_nxt = (total_samples_in == 32'd0) ? DONE : STREAM;
      end
      STREAM: begin
        busy_out = 1'b1;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts when tready is high.
        bus.sample_ready_out = (!fifo_full || bus.m_axis_tready) && (in_cnt < len);
        bus.m_axis_tvalid    = !fifo_empty;
        bus.m_axis_tlast     = !fifo_empty && last_pos;
        if (!fifo_empty) bus.m_axis_tdata = {16'h0000, re_part};
        if ((in_cnt == len) && fifo_empty) state_nxt = (pos == '0) ? DONE : PAD;
      end
      PAD: begin
        busy_out          = 1'b1;
        bus.m_axis_tvalid = 1'b1;
        bus.m_axis_tlast  = last_pos;
        if (bus.m_axis_tready && last_pos) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.sample_in;
  end

  // Pointers, session counters, frame position and progress reporting.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      len             <= 32'd0;
      in_cnt          <= 32'd0;
      pos             <= '0;
      frame_count_out <= 16'h0;
      frame_done_out  <= 1'b0;
    end else begin
      frame_done_out <= last_hs;
      if (start_ok) begin
        len             <= total_samples_in;
        in_cnt          <= 32'd0;
        pos             <= '0;
        frame_count_out <= 16'h0;
        wr_ptr          <= '0;
        rd_ptr          <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + (AW+1)'(1);
          in_cnt <= in_cnt + 32'd1;
        end
        if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        if (out_hs) pos <= last_pos ? '0 : pos + PW'(1);
        if (last_hs && (frame_count_out != 16'hFFFF)) frame_count_out <= frame_count_out + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder with FRAME_LEN=8: a negedge monitor keeps a
// scoreboard of accepted samples and checks every output word, tlast and frame_done.
module tb_fft_frame_feeder;
  localparam int FL = 8;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic [31:0] total_samples_in;
  logic        frame_done_out;
  logic [15:0] frame_count_out;
  logic        busy_out;

  fft_frame_feeder_if #(.SAMPLE_W(8)) bus_if ();

  fft_frame_feeder #(.FRAME_LEN(FL), .SAMPLE_W(8), .FIFO_DEPTH(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .total_samples_in(total_samples_in), .bus(bus_if),
    .frame_done_out(frame_done_out), .frame_count_out(frame_count_out),
    .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int mon_checks = 0, mon_errs = 0, st_checks = 0, st_errs = 0;
  int in_acc = 0, out_words = 0, pad_words = 0, tlast_cnt = 0, fdone_cnt = 0;
  int word_idx = 0, occ = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w, held_data;
  logic        held_last, prev_stall = 1'b0, prev_lhs = 1'b0;

  task automatic mchk(string tag, logic [31:0] got, logic [31:0] exp);
    mon_checks++;
    assert (got === exp) else begin
      mon_errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    st_checks++;
    assert (got === exp) else begin
      st_errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: evaluates the handshakes that complete at the coming posedge.
  always @(negedge clk_in) begin
    if (rst_in) begin
      exp_q.delete();
      word_idx   = 0;
      occ        = 0;
      prev_stall = 1'b0;
      prev_lhs   = 1'b0;
    end else begin
      mchk("tlast_pos", {31'd0, bus_if.m_axis_tlast},
           {31'd0, bus_if.m_axis_tvalid && (word_idx % FL == FL - 1)});
      mchk("frame_done", {31'd0, frame_done_out}, {31'd0, prev_lhs});
      if (frame_done_out) fdone_cnt++;
      if (prev_stall)
        mchk("stall_hold", {bus_if.m_axis_tvalid, bus_if.m_axis_tlast, bus_if.m_axis_tdata[29:0]},
             {1'b1, held_last, held_data[29:0]});
      if (!bus_if.m_axis_tready && occ == 16)
        mchk("ready_full", {31'd0, bus_if.sample_ready_out}, 32'd0);
      prev_lhs   = bus_if.m_axis_tvalid && bus_if.m_axis_tready && bus_if.m_axis_tlast;
      prev_stall = bus_if.m_axis_tvalid && !bus_if.m_axis_tready;
      held_data  = bus_if.m_axis_tdata;
      held_last  = bus_if.m_axis_tlast;
      if (bus_if.m_axis_tvalid && bus_if.m_axis_tready) begin
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          occ--;
        end else begin
          exp_w = 32'h0;
          pad_words++;
        end
        mchk("tdata", bus_if.m_axis_tdata, exp_w);
        if (bus_if.m_axis_tlast) tlast_cnt++;
        out_words++;
        word_idx++;
      end
      if (bus_if.sample_valid_in && bus_if.sample_ready_out) begin
        exp_q.push_back({16'h0000, bus_if.sample_in, 8'h00});
        occ++;
        in_acc++;
        mchk("occupancy", (occ <= 16) ? 32'd1 : 32'd0, 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic start_session(input int total);
    tick();
    total_samples_in = 32'(total);
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  // mode 0: continuous valid, tready=1; mode 1: random valid, tready toggling.
  task automatic run_stream(input int total, input int mode, input int pulse_at, input int mul);
    int acc0, cyc, k;
    acc0 = in_acc;
    cyc  = 0;
    start_session(total);
    while (busy_out && cyc < 2000) begin
      k = in_acc - acc0;
      bus_if.sample_valid_in = (k < total) && ((mode == 0) || ($urandom_range(0, 1) == 1));
      bus_if.sample_in       = 8'(k * mul + 1);
      bus_if.m_axis_tready   = (mode == 0) ? 1'b1 : cyc[0];
      start_in               = (cyc == pulse_at);
      total_samples_in       = 32'd3;
      tick();
      cyc++;
    end
    chk("session_timeout", (cyc < 2000) ? 32'd1 : 32'd0, 32'd1);
    bus_if.sample_valid_in = 1'b0;
    bus_if.m_axis_tready   = 1'b1;
    start_in               = 1'b0;
    tick();
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_tvalid"}, {31'd0, bus_if.m_axis_tvalid}, 32'd0);
    chk({tag, "_tlast"}, {31'd0, bus_if.m_axis_tlast}, 32'd0);
    chk({tag, "_tdata"}, bus_if.m_axis_tdata, 32'd0);
    chk({tag, "_ready"}, {31'd0, bus_if.sample_ready_out}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_out}, 32'd0);
    chk({tag, "_fdone"}, {31'd0, frame_done_out}, 32'd0);
    chk({tag, "_fcount"}, {16'd0, frame_count_out}, 32'd0);
  endtask

  int w0, p0, t0, f0, a0, cyc;

  initial begin
    rst_in = 1'b1;
    start_in = 1'b0;
    total_samples_in = 32'd0;
    bus_if.sample_in = 8'h00;
    bus_if.sample_valid_in = 1'b0;
    bus_if.m_axis_tready = 1'b1;
    #23;
    check_quiet("reset");
    rst_in = 1'b0;
    tick();

    // Exact multiple of the frame length: no padding.
    w0 = out_words; p0 = pad_words; t0 = tlast_cnt; f0 = fdone_cnt;
    run_stream(16, 0, -1, 1);
    chk("exact_words", 32'(out_words - w0), 32'd16);
    chk("exact_pads", 32'(pad_words - p0), 32'd0);
    chk("exact_tlast", 32'(tlast_cnt - t0), 32'd2);
    chk("exact_fdone", 32'(fdone_cnt - f0), 32'd2);
    chk("exact_fcount", {16'd0, frame_count_out}, 32'd2);
    chk("exact_idle_busy", {31'd0, busy_out}, 32'd0);

    // Partial final frame is zero-padded to a full frame.
    w0 = out_words; p0 = pad_words; t0 = tlast_cnt;
    run_stream(11, 0, -1, 1);
    chk("pad_words", 32'(out_words - w0), 32'd16);
    chk("pad_zero_words", 32'(pad_words - p0), 32'd5);
    chk("pad_tlast", 32'(tlast_cnt - t0), 32'd2);
    chk("pad_fcount", {16'd0, frame_count_out}, 32'd2);

    // Backpressure with random input valid; negative sample values included.
    w0 = out_words; p0 = pad_words;
    run_stream(40, 1, -1, 37);
    chk("bp_words", 32'(out_words - w0), 32'd40);
    chk("bp_pads", 32'(pad_words - p0), 32'd0);
    chk("bp_fcount", {16'd0, frame_count_out}, 32'd5);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Fill to full with the sink stalled, then push and pop together every cycle.
    w0 = out_words; p0 = pad_words; a0 = in_acc; cyc = 0;
    start_session(36);
    bus_if.m_axis_tready = 1'b0;
    while ((in_acc - a0) < 16 && cyc < 100) begin
      bus_if.sample_valid_in = 1'b1;
      bus_if.sample_in = 8'(200 + in_acc - a0);
      tick();
      cyc++;
    end
    chk("full_fill_count", 32'(in_acc - a0), 32'd16);
    bus_if.sample_in = 8'(200 + in_acc - a0);
    chk("full_ready_low", {31'd0, bus_if.sample_ready_out}, 32'd0);
    chk("full_tvalid", {31'd0, bus_if.m_axis_tvalid}, 32'd1);
    a0 = in_acc;
    bus_if.m_axis_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus_if.sample_in = 8'(216 + i);
      #1;
      chk("full_ready_high", {31'd0, bus_if.sample_ready_out}, 32'd1);
      tick();
    end
    chk("full_push_pop", 32'(in_acc - a0), 32'd20);
    bus_if.sample_valid_in = 1'b0;
    cyc = 0;
    while (busy_out && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("full_drain_timeout", (cyc < 200) ? 32'd1 : 32'd0, 32'd1);
    chk("full_words", 32'(out_words - w0), 32'd40);
    chk("full_pads", 32'(pad_words - p0), 32'd4);
    chk("full_fcount", {16'd0, frame_count_out}, 32'd5);
    tick();

    // Zero-length session goes straight to DONE, dropping any offered samples.
    w0 = out_words; a0 = in_acc;
    bus_if.sample_valid_in = 1'b1;
    start_session(0);
    chk("zero_busy", {31'd0, busy_out}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("zero_words", 32'(out_words - w0), 32'd0);
    chk("zero_accepted", 32'(in_acc - a0), 32'd0);
    chk("zero_ready", {31'd0, bus_if.sample_ready_out}, 32'd0);
    bus_if.sample_valid_in = 1'b0;

    // A start pulse mid-stream must not disturb the session.
    w0 = out_words; p0 = pad_words;
    run_stream(16, 0, 5, 3);
    chk("restart_words", 32'(out_words - w0), 32'd16);
    chk("restart_pads", 32'(pad_words - p0), 32'd0);
    chk("restart_fcount", {16'd0, frame_count_out}, 32'd2);

    // Reset in the middle of a frame at pos=3.
    w0 = out_words; cyc = 0; a0 = in_acc;
    start_session(16);
    bus_if.m_axis_tready = 1'b1;
    while ((out_words - w0) < 3 && cyc < 100) begin
      bus_if.sample_valid_in = 1'b1;
      bus_if.sample_in = 8'(in_acc - a0 + 1);
      tick();
      cyc++;
    end
    chk("midrst_reached", 32'(out_words - w0), 32'd3);
    rst_in = 1'b1;
    bus_if.sample_valid_in = 1'b0;
    #1;
    check_quiet("midrst");
    tick();
    tick();
    rst_in = 1'b0;
    tick();
    w0 = out_words; p0 = pad_words; t0 = tlast_cnt;
    run_stream(8, 0, -1, 5);
    chk("post_rst_words", 32'(out_words - w0), 32'd8);
    chk("post_rst_tlast", 32'(tlast_cnt - t0), 32'd1);
    chk("post_rst_pads", 32'(pad_words - p0), 32'd0);
    chk("post_rst_fcount", {16'd0, frame_count_out}, 32'd1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             mon_checks + st_checks, mon_errs + st_errs);
    $finish;
  end
endmodule
